// File: rtl/uart_core.sv
// Full-duplex UART: synchronised mid-bit-sampling receiver with parity/framing
// checks and break guard, plus an independent frame serializer for transmit.
module uart_core #(
    parameter int unsigned CLK_DIV     = 2604,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_EN   = 0,
    parameter int unsigned PARITY_ODD  = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 tx_vld,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 txrdy,
    output logic                 tx,
    output logic                 rx_vld,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_busy
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLK_DIV / 2);
    localparam logic [BIT_W-1:0] DATA_LST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_INV  = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BRK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    // ---------------- receive path ----------------
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    logic                   w_rxs;
    rx_state_t              r_rx_state;
    rx_state_t              w_rx_nxt;
    logic [CNT_W-1:0]       r_rx_cnt;
    logic [BIT_W-1:0]       r_rx_bit;
    logic [DATA_BITS-1:0]   r_rx_shift;
    logic                   r_rx_perr_acc;
    logic                   w_rx_smp;
    logic                   w_rx_shift_en;
    logic                   w_rx_par_en;
    logic                   w_rx_done;
    logic                   r_rx_vld;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_rx_perr;
    logic                   r_rx_ferr;
    logic                   r_rx_busy;

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rxs_d <= w_rxs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_nxt;
    end

    // Counter is only resynchronised by the start edge (held at 0 in IDLE).
    assign w_rx_smp = (r_rx_cnt == CNT_MID) &&
                      (r_rx_state != RX_IDLE) && (r_rx_state != RX_BRK);

    always_comb begin
        w_rx_nxt = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (r_rxs_d && !w_rxs) w_rx_nxt = RX_START;
            RX_START: if (w_rx_smp) w_rx_nxt = w_rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_smp && (r_rx_bit == DATA_LST))
                          w_rx_nxt = (PARITY_EN != 0) ? RX_PAR : RX_STOP;
            RX_PAR:   if (w_rx_smp) w_rx_nxt = RX_STOP;
            RX_STOP:  if (w_rx_smp) w_rx_nxt = w_rxs ? RX_IDLE : RX_BRK;
            RX_BRK:   if (w_rxs) w_rx_nxt = RX_IDLE;
            default:  w_rx_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_shift_en = 1'b0;
        w_rx_par_en   = 1'b0;
        w_rx_done     = 1'b0;
        case (r_rx_state)
            RX_DATA: w_rx_shift_en = w_rx_smp;
            RX_PAR:  w_rx_par_en   = w_rx_smp;
            RX_STOP: w_rx_done     = w_rx_smp;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt      <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_perr_acc <= 1'b0;
        end else begin
            if (r_rx_state == RX_IDLE)  r_rx_cnt <= '0;
            else if (r_rx_cnt == CNT_MAX) r_rx_cnt <= '0;
            else                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);

            if (r_rx_state != RX_DATA) r_rx_bit <= '0;
            else if (w_rx_shift_en)    r_rx_bit <= r_rx_bit + BIT_W'(1);

            if (w_rx_shift_en) r_rx_shift <= {w_rxs, r_rx_shift[DATA_BITS-1:1]};

            if (r_rx_state == RX_IDLE) r_rx_perr_acc <= 1'b0;
            else if (w_rx_par_en)      r_rx_perr_acc <= w_rxs ^ (^r_rx_shift) ^ PAR_INV;
        end
    end

    // Data is delivered even on a framing error; flags are single-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_vld  <= 1'b0;
            r_rx_data <= '0;
            r_rx_perr <= 1'b0;
            r_rx_ferr <= 1'b0;
            r_rx_busy <= 1'b0;
        end else begin
            r_rx_vld  <= w_rx_done;
            r_rx_perr <= w_rx_done & r_rx_perr_acc;
            r_rx_ferr <= w_rx_done & ~w_rxs;
            r_rx_busy <= (w_rx_nxt != RX_IDLE);
            if (w_rx_done) r_rx_data <= r_rx_shift;
        end
    end

    assign rx_vld  = r_rx_vld;
    assign rx_data = r_rx_data;
    assign rx_perr = r_rx_perr;
    assign rx_ferr = r_rx_ferr;
    assign rx_busy = r_rx_busy;

    // ---------------- transmit path ----------------
    tx_state_t            r_tx_state;
    tx_state_t            w_tx_nxt;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [BIT_W-1:0]     r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [DATA_BITS-1:0] w_tx_shift_nxt;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_txrdy;
    logic                 w_tx_acc;
    logic                 w_tx_end;
    logic                 w_tx_bit_nxt;

    assign w_tx_acc = (r_tx_state == TX_IDLE) && tx_vld;
    assign w_tx_end = (r_tx_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_nxt;
    end

    always_comb begin
        w_tx_nxt = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_acc) w_tx_nxt = TX_START;
            TX_START: if (w_tx_end) w_tx_nxt = TX_DATA;
            TX_DATA:  if (w_tx_end && (r_tx_bit == DATA_LST))
                          w_tx_nxt = (PARITY_EN != 0) ? TX_PAR : TX_STOP;
            TX_PAR:   if (w_tx_end) w_tx_nxt = TX_STOP;
            TX_STOP:  if (w_tx_end && (r_tx_bit == STOP_LST)) w_tx_nxt = TX_IDLE;
            default:  w_tx_nxt = TX_IDLE;
        endcase
    end

    // The line level is registered from the next state so tx is glitch-free.
    always_comb begin
        w_tx_shift_nxt = r_tx_shift;
        if (w_tx_acc)
            w_tx_shift_nxt = tx_data;
        else if ((r_tx_state == TX_DATA) && w_tx_end)
            w_tx_shift_nxt = r_tx_shift >> 1;

        w_tx_bit_nxt = 1'b1;
        case (w_tx_nxt)
            TX_START: w_tx_bit_nxt = 1'b0;
            TX_DATA:  w_tx_bit_nxt = w_tx_shift_nxt[0];
            TX_PAR:   w_tx_bit_nxt = r_tx_par;
            default:  w_tx_bit_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_txrdy    <= 1'b1;
        end else begin
            if (r_tx_state == TX_IDLE) r_tx_cnt <= '0;
            else if (w_tx_end)         r_tx_cnt <= '0;
            else                       r_tx_cnt <= r_tx_cnt + CNT_W'(1);

            if (w_tx_nxt != r_tx_state) r_tx_bit <= '0;
            else if (w_tx_end)          r_tx_bit <= r_tx_bit + BIT_W'(1);

            if (w_tx_acc) r_tx_par <= (^tx_data) ^ PAR_INV;

            r_tx_shift <= w_tx_shift_nxt;
            r_tx       <= w_tx_bit_nxt;
            r_txrdy    <= (w_tx_nxt == TX_IDLE);
        end
    end

    assign tx    = r_tx;
    assign txrdy = r_txrdy;

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: an 8N1 instance and an even-parity instance,
// both at 16 clocks per bit.
module tb_uart_core;

    localparam int unsigned DIV = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_p;
    logic       tx_vld, tx_vld_p;
    logic [7:0] tx_data, tx_data_p;
    logic       txrdy, tx, rx_vld_a, rx_perr_a, rx_ferr_a, rx_busy_a;
    logic [7:0] rx_data_a;
    logic       txrdy_p, tx_p, rx_vld_p, rx_perr_p, rx_ferr_p, rx_busy_p;
    logic [7:0] rx_data_p;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_start = 0;
    int vld_a = 0;
    int vld_p = 0;
    int vld_cyc_a = 0;
    logic [7:0] last_a = 8'h00;
    logic [7:0] last_p = 8'h00;
    logic last_perr_a = 1'b0, last_ferr_a = 1'b0;
    logic last_perr_p = 1'b0, last_ferr_p = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0),
                .STOP_BITS(1), .SYNC_STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .tx_vld(tx_vld), .tx_data(tx_data),
        .txrdy(txrdy), .tx(tx), .rx_vld(rx_vld_a), .rx_data(rx_data_a),
        .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rx_busy(rx_busy_a)
    );

    uart_core #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0),
                .STOP_BITS(1), .SYNC_STAGES(4)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .tx_vld(tx_vld_p), .tx_data(tx_data_p),
        .txrdy(txrdy_p), .tx(tx_p), .rx_vld(rx_vld_p), .rx_data(rx_data_p),
        .rx_perr(rx_perr_p), .rx_ferr(rx_ferr_p), .rx_busy(rx_busy_p)
    );

    always @(negedge clk) begin
        if (rx_vld_a) begin
            vld_a       = vld_a + 1;
            vld_cyc_a   = cyc;
            last_a      = rx_data_a;
            last_perr_a = rx_perr_a;
            last_ferr_a = rx_ferr_a;
        end
        if (rx_vld_p) begin
            vld_p       = vld_p + 1;
            last_p      = rx_data_p;
            last_perr_p = rx_perr_p;
            last_ferr_p = rx_ferr_p;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_bit(input int sel, input logic b);
        if (sel == 0) rx_a = b;
        else          rx_p = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        t_start = cyc;
        rx_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) rx_bit(sel, d[i]);
        if (has_par) rx_bit(sel, par);
        rx_bit(sel, stop);
    endtask

    // Accept one word, then check mid-bit line levels and the txrdy window.
    task automatic check_tx(input logic [7:0] d, input string tag);
        logic [9:0] exp_bits;
        int low_cnt;
        int first_hi;
        exp_bits = {1'b1, d, 1'b0};
        low_cnt  = 0;
        first_hi = 0;
        @(negedge clk);
        chk({tag, "_rdy_pre"}, 32'(txrdy), 32'd1);
        tx_data = d;
        tx_vld  = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 175; i++) begin
            @(negedge clk);
            if (i == 1) begin
                tx_vld  = 1'b0;
                tx_data = 8'h00;
                chk({tag, "_low_at_once"}, 32'(tx), 32'd0);
            end
            if (((i - 1) % 16 == 8) && ((i - 1) / 16 < 10))
                chk($sformatf("%s_bit%0d", tag, (i - 1) / 16), 32'(tx),
                    32'(exp_bits[(i - 1) / 16]));
            if (!txrdy) low_cnt = low_cnt + 1;
            else if (first_hi == 0) first_hi = i;
        end
        chk({tag, "_rdy_low_cycles"}, 32'(low_cnt), 32'd160);
        chk({tag, "_rdy_high_cycle"}, 32'(first_hi), 32'd161);
        chk({tag, "_idle_high"}, 32'(tx), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        rx_a      = 1'b1;
        rx_p      = 1'b1;
        tx_vld    = 1'b0;
        tx_data   = 8'h00;
        tx_vld_p  = 1'b0;
        tx_data_p = 8'h00;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_tx",      32'(tx),        32'd1);
        chk("rst_txrdy",   32'(txrdy),     32'd1);
        chk("rst_rx_vld",  32'(rx_vld_a),  32'd0);
        chk("rst_rx_busy", 32'(rx_busy_a), 32'd0);
        chk("rst_rx_data", 32'(rx_data_a), 32'd0);
        chk("rst_flags",   32'({rx_perr_a, rx_ferr_a}), 32'd0);
        chk("rst_p_tx",    32'({tx_p, txrdy_p}), 32'd3);
        chk("rst_p_rx",    32'({rx_vld_p, rx_busy_p, rx_perr_p, rx_ferr_p}), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 receive of 0xA5
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("a5_count", 32'(vld_a), 32'd1);
        chk("a5_data",  32'(last_a), 32'hA5);
        chk("a5_flags", 32'({last_perr_a, last_ferr_a}), 32'd0);
        chk("a5_latency", 32'((vld_cyc_a - t_start >= 150) && (vld_cyc_a - t_start <= 165)), 32'd1);
        chk("a5_busy_done", 32'(rx_busy_a), 32'd0);

        // 8N1 transmit of 0x3C
        check_tx(8'h3C, "tx3c");

        // even parity: 0x07 has odd weight, so the correct parity bit is 1
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("par0_count", 32'(vld_p), 32'd1);
        chk("par0_data",  32'(last_p), 32'h07);
        chk("par0_perr",  32'(last_perr_p), 32'd1);
        chk("par0_ferr",  32'(last_ferr_p), 32'd0);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        chk("par1_count", 32'(vld_p), 32'd2);
        chk("par1_perr",  32'(last_perr_p), 32'd0);

        // 3-cycle glitch rejected at the mid-start sample
        rx_a = 1'b0;
        repeat (3) @(negedge clk);
        rx_a = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_busy_set", 32'(rx_busy_a), 32'd1);
        repeat (10) @(negedge clk);
        chk("glitch_busy_clr", 32'(rx_busy_a), 32'd0);
        chk("glitch_no_vld",   32'(vld_a), 32'd1);
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("x55_count", 32'(vld_a), 32'd2);
        chk("x55_data",  32'(last_a), 32'h55);

        // line break: one flagged all-zero word, then silence until rx rises
        rx_a = 1'b0;
        repeat (480) @(negedge clk);
        chk("brk_count", 32'(vld_a), 32'd3);
        chk("brk_data",  32'(last_a), 32'h00);
        chk("brk_ferr",  32'(last_ferr_a), 32'd1);
        chk("brk_busy",  32'(rx_busy_a), 32'd1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        chk("brk_end_count", 32'(vld_a), 32'd3);
        chk("brk_end_busy",  32'(rx_busy_a), 32'd0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        chk("x81_count", 32'(vld_a), 32'd4);
        chk("x81_data",  32'(last_a), 32'h81);
        chk("x81_ferr",  32'(last_ferr_a), 32'd0);

        // reset in the middle of a TX frame and an RX frame
        rx_a    = 1'b0;
        tx_data = 8'hF0;
        tx_vld  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_vld = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_tx_low",   32'(tx), 32'd0);
        chk("mid_txrdy",    32'(txrdy), 32'd0);
        chk("mid_rx_busy",  32'(rx_busy_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx",      32'(tx), 32'd1);
        chk("arst_txrdy",   32'(txrdy), 32'd1);
        chk("arst_rx_busy", 32'(rx_busy_a), 32'd0);
        rx_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("arst_no_vld", 32'(vld_a), 32'd4);
        check_tx(8'h96, "tx96");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Parametrised full-duplex UART: oversampling-free receiver plus complete transmitter, with configurable data width, parity and stop bits.
Successor to the fixed 8N1 receive path. Adds a real TX serializer, start-bit glitch rejection, parity and framing error flags, and a line-break guard.
Sits between the board-level serial pins and the byte-level command/loopback logic.

Parameters:
CLK_DIV, 2604, clk cycles per bit; legal range 4..65535 (2604 gives 19200 baud at 50 MHz)
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY_EN, 0, 1 adds a parity bit after the data
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0
STOP_BITS, 1, stop bits transmitted, 1 or 2; receiver checks the first stop bit only
SYNC_STAGES, 4, synchroniser flops on rx; legal range 2..6

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  serial input, idle high, asynchronous to clk
tx_vld  in  1  transmit request, qualified by txrdy
tx_data  in  DATA_BITS  byte to send; sampled on accept
txrdy  out  1  transmitter can accept
tx  out  1  serial output, idle high
rx_vld  out  1  one-cycle pulse: rx_data/rx_perr/rx_ferr valid
rx_data  out  DATA_BITS  last received word; held until the next rx_vld
rx_perr  out  1  parity error for the current rx_vld, same-cycle pulse
rx_ferr  out  1  framing error for the current rx_vld, same-cycle pulse
rx_busy  out  1  receiver is inside a frame

Behaviour:
- Reset (rst_n low, asynchronous): all synchroniser flops = 1, tx = 1, txrdy = 1, rx_vld = 0, rx_perr = 0, rx_ferr = 0, rx_busy = 0, rx_data = 0, both FSMs IDLE, counters 0.
- Clock and reset handling: one clk domain, async-assert reset for all flops. rx passes through SYNC_STAGES flops; "rxs" denotes the final stage.
- Bit order: LSB first on both TX and RX. Parity is computed over the DATA_BITS data bits only. Even parity: parity bit = XOR of data. Odd parity: parity bit = inverted XOR.
- RX FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: on a rxs 1->0 transition, bit counter = 0, go to START, rx_busy = 1.
  - Bit counter runs 0..CLK_DIV-1 and wraps. Sample point is count == CLK_DIV/2 (integer division). The counter is resynchronised only at the start edge, not on data edges.
  - START sample: rxs = 1 means a glitch; return to IDLE with no output. rxs = 0 means go to DATA.
  - DATA: shift DATA_BITS samples into the shift register. Then go to PAR if PARITY_EN, else STOP.
  - PAR: sample the parity bit and record a mismatch.
  - STOP: sample the first stop bit. rx_data <= shift register in the same cycle. rx_vld pulses the next cycle with rx_perr/rx_ferr. rx_ferr = 1 when the sampled stop bit is 0.
  - After STOP: if the stop bit was 1, go to IDLE and clear rx_busy. This happens mid-stop-bit, so back-to-back frames are caught.
  - If the stop bit was 0, go to BRK. Stay in BRK until rxs == 1, then go to IDLE. No new start is detected during a break.
  - rx_data is updated on a framing error too (the data is delivered, flagged).
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - txrdy = 1 only in IDLE. Accept occurs on the edge where tx_vld & txrdy. tx_data is latched at accept; tx_vld while txrdy = 0 is ignored (no queue).
  - tx goes low on the cycle after accept.
  - Each bit lasts exactly CLK_DIV cycles, in this order: start, DATA_BITS data bits, parity if enabled, STOP_BITS stop bits (high).
  - txrdy returns to 1 in the cycle after the last stop bit completes. Accept-to-txrdy = (1+DATA_BITS+PARITY_EN+STOP_BITS)*CLK_DIV + 1 cycles.
  - tx_vld held high gives back-to-back frames with no idle gap beyond the stop bits.
- RX and TX are fully independent. Simultaneous activity has no interaction.
- Reset mid-frame: tx goes to 1 immediately (asynchronously); any partial RX frame is discarded with no rx_vld.

Test Plan:
- CLK_DIV=16, 8N1, rx driven with frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) -> one rx_vld pulse, rx_data=0xA5, perr=0, ferr=0; rx_vld lands ~9.5 bit times (~152 cycles) after the start edge.
- tx_vld with tx_data=0x3C for 1 cycle, 8N1, CLK_DIV=16 -> tx low 16 cycles, then 0,0,1,1,1,1,0,0 at 16 cycles each, then high; txrdy low for 160 cycles then high on cycle 161.
- PARITY_EN=1, PARITY_ODD=0: receive 0x07 with parity bit 0 -> rx_data=0x07, rx_perr=1. With parity bit 1 -> rx_perr=0.
- 3-cycle low glitch on idle rx -> no rx_vld, rx_busy returns to 0 after the mid-start sample. Then a valid 0x55 frame -> rx_data=0x55.
- rx held low for 3 frame times (break) -> one rx_vld with rx_data=0x00 and rx_ferr=1, no further rx_vld until rx high. A following 0x81 frame is received correctly.
- rst_n pulsed low mid-TX and mid-RX -> tx=1 and txrdy=1 at once, no rx_vld. A new tx_vld after reset starts a clean frame.
